// File: rtl/axis_switch_sched_out.sv
// Packet-level AXI-Stream demultiplexer: routes scheduler packets to one of NMASTERS streams by tdest.
// Optional saturating dropped-packet counter enabled by AXIS_SWITCH_SCHED_OUT_DROP_CNT_EN.
//
// state | meaning
// IDLE  | at a packet boundary, no route locked
// FWD   | route locked to r_sel until the tlast beat is accepted
// DROP  | discarding the remainder of a packet with an invalid tdest
module axis_switch_sched_out #(
  parameter  int NMASTERS   = 4,
  parameter  int ID_WIDTH   = 8,
  parameter  int DEST_WIDTH = 4,
  localparam int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic [ID_WIDTH-1:0]   S_AXIS_tid,
  input  logic [DEST_WIDTH-1:0] S_AXIS_tdest,
  input  logic                  S_AXIS_tlast,
  output logic [NMASTERS-1:0]   M_AXIS_tvalid,
  input  logic [NMASTERS-1:0]   M_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [ID_WIDTH-1:0]   M_AXIS_tid,
  output logic                  M_AXIS_tlast,
  output logic [15:0]           drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_out_valid;
  logic [DEST_WIDTH-1:0] r_sel;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_last;

  logic w_sel_ready;
  logic w_dest_ok;
  logic w_pass_ready;
  logic w_drain;
  logic w_accept;
  logic w_load;

  assign w_dest_ok    = (int'(S_AXIS_tdest) < NMASTERS);
  assign w_pass_ready = !r_out_valid || w_sel_ready;
  assign w_drain      = r_out_valid && w_sel_ready;
  assign w_accept     = S_AXIS_tvalid && S_AXIS_tready;

  // Only the selected master's ready matters; the others are ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (r_sel == DEST_WIDTH'(i)) w_sel_ready = M_AXIS_tready[i];
    end
  end

  always_comb begin
    M_AXIS_tvalid = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      M_AXIS_tvalid[i] = r_out_valid && (r_sel == DEST_WIDTH'(i));
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    S_AXIS_tready = 1'b0;
    w_load        = 1'b0;
    unique case (r_state)
      IDLE: begin
        S_AXIS_tready = w_dest_ok ? w_pass_ready : 1'b1;
        if (w_accept) begin
          w_load = w_dest_ok;
          if (!S_AXIS_tlast) w_state_nxt = w_dest_ok ? FWD : DROP;
        end
      end
      FWD: begin
        S_AXIS_tready = w_pass_ready;
        if (w_accept) begin
          w_load = 1'b1;
          if (S_AXIS_tlast) w_state_nxt = IDLE;
        end
      end
      DROP: begin
        S_AXIS_tready = 1'b1;
        if (w_accept && S_AXIS_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // The combinational ready path must not signal acceptance while reset is held.
    if (rst) S_AXIS_tready = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sel       <= '0;
      r_data      <= '0;
      r_id        <= '0;
      r_last      <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_data      <= S_AXIS_tdata;
      r_id        <= S_AXIS_tid;
      r_last      <= S_AXIS_tlast;
      if (r_state == IDLE) r_sel <= S_AXIS_tdest;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign M_AXIS_tdata = r_data;
  assign M_AXIS_tid   = r_id;
  assign M_AXIS_tlast = r_last;

`ifdef AXIS_SWITCH_SCHED_OUT_DROP_CNT_EN
  logic        w_drop_first;
  logic [15:0] r_drop_count;

  assign w_drop_first = w_accept && (r_state == IDLE) && !w_dest_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop_first && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_switch_sched_out.sv
// Directed self-checking bench for axis_switch_sched_out (NMASTERS=4).
module tb_axis_switch_sched_out;

`ifdef AXIS_SWITCH_SCHED_OUT_DROP_CNT_EN
  localparam logic [15:0] DROP_INC = 16'd1;
`else
  localparam logic [15:0] DROP_INC = 16'd0;
`endif

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic [7:0]  s_tid;
  logic [3:0]  s_tdest;
  logic        s_tlast;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tid;
  logic        m_tlast;
  logic [15:0] drop_count;

  int n_vec;
  int n_err;

  axis_switch_sched_out #(
    .NMASTERS  (4),
    .ID_WIDTH  (8),
    .DEST_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .S_AXIS_tvalid(s_tvalid),
    .S_AXIS_tready(s_tready),
    .S_AXIS_tdata (s_tdata),
    .S_AXIS_tid   (s_tid),
    .S_AXIS_tdest (s_tdest),
    .S_AXIS_tlast (s_tlast),
    .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tready(m_tready),
    .M_AXIS_tdata (m_tdata),
    .M_AXIS_tid   (m_tid),
    .M_AXIS_tlast (m_tlast),
    .drop_count   (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] id,
                       input logic [3:0] dest, input logic last);
    s_tvalid = v;
    s_tdata  = d;
    s_tid    = id;
    s_tdest  = dest;
    s_tlast  = last;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 8'h0, 4'h0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    m_tready = 4'hF;
    drive(1'b1, 64'hDEAD, 8'h1, 4'h0, 1'b1);

    // reset state
    #3;
    chk("rst_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_tready", 64'(s_tready), 64'h0);
    chk("rst_tdata", m_tdata, 64'h0);
    chk("rst_drop", 64'(drop_count), 64'h0);
    @(negedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    step();
    chk("post_rst_tvalid", 64'(m_tvalid), 64'h0);

    // single-beat routing
    drive(1'b1, 64'hA5, 8'd7, 4'd2, 1'b1);
    #1 chk("sb_tready", 64'(s_tready), 64'h1);
    step();
    idle();
    chk("sb_tvalid", 64'(m_tvalid), 64'h4);
    chk("sb_tdata", m_tdata, 64'hA5);
    chk("sb_tid", 64'(m_tid), 64'd7);
    chk("sb_tlast", 64'(m_tlast), 64'h1);
    step();
    chk("sb_tvalid_off", 64'(m_tvalid), 64'h0);

    // route lock: later beats carry tdest=3 but stay on master 1
    drive(1'b1, 64'h11, 8'd1, 4'd1, 1'b0);
    step();
    chk("lock_b0_tvalid", 64'(m_tvalid), 64'h2);
    chk("lock_b0_tdata", m_tdata, 64'h11);
    drive(1'b1, 64'h22, 8'd1, 4'd3, 1'b0);
    #1 chk("lock_b1_tready", 64'(s_tready), 64'h1);
    step();
    chk("lock_b1_tvalid", 64'(m_tvalid), 64'h2);
    chk("lock_b1_tdata", m_tdata, 64'h22);
    chk("lock_b1_tlast", 64'(m_tlast), 64'h0);
    drive(1'b1, 64'h33, 8'd1, 4'd3, 1'b1);
    step();
    idle();
    chk("lock_b2_tvalid", 64'(m_tvalid), 64'h2);
    chk("lock_b2_tdata", m_tdata, 64'h33);
    chk("lock_b2_tlast", 64'(m_tlast), 64'h1);
    step();
    chk("lock_end_tvalid", 64'(m_tvalid), 64'h0);

    // back-pressure on master 0 (other masters ready, must be ignored)
    m_tready = 4'b1110;
    drive(1'b1, 64'h40, 8'd4, 4'd0, 1'b0);
    #1 chk("bp_first_tready", 64'(s_tready), 64'h1);
    step();
    drive(1'b1, 64'h41, 8'd4, 4'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_tready", 64'(s_tready), 64'h0);
      chk("bp_hold_tvalid", 64'(m_tvalid), 64'h1);
      chk("bp_hold_tdata", m_tdata, 64'h40);
      step();
    end
    m_tready = 4'hF;
    #1 chk("bp_release_tready", 64'(s_tready), 64'h1);
    step();
    chk("bp_b1_tdata", m_tdata, 64'h41);
    chk("bp_b1_tvalid", 64'(m_tvalid), 64'h1);
    drive(1'b1, 64'h42, 8'd4, 4'd0, 1'b0);
    step();
    chk("bp_b2_tdata", m_tdata, 64'h42);
    drive(1'b1, 64'h43, 8'd4, 4'd0, 1'b1);
    step();
    idle();
    chk("bp_b3_tdata", m_tdata, 64'h43);
    chk("bp_b3_tlast", 64'(m_tlast), 64'h1);
    chk("bp_b3_tvalid", 64'(m_tvalid), 64'h1);
    step();
    chk("bp_end_tvalid", 64'(m_tvalid), 64'h0);

    // boundary switch: dest 0,0 then dest 3 with no bubble
    drive(1'b1, 64'hA0, 8'd2, 4'd0, 1'b0);
    step();
    chk("bs_a0_tvalid", 64'(m_tvalid), 64'h1);
    drive(1'b1, 64'hA1, 8'd2, 4'd0, 1'b1);
    step();
    chk("bs_a1_tvalid", 64'(m_tvalid), 64'h1);
    chk("bs_a1_tdata", m_tdata, 64'hA1);
    drive(1'b1, 64'hB0, 8'd3, 4'd3, 1'b1);
    #1 chk("bs_b_tready", 64'(s_tready), 64'h1);
    step();
    idle();
    chk("bs_b_tvalid", 64'(m_tvalid), 64'h8);
    chk("bs_b_tdata", m_tdata, 64'hB0);
    chk("bs_b_tid", 64'(m_tid), 64'd3);
    step();
    chk("bs_end_tvalid", 64'(m_tvalid), 64'h0);

    // invalid dest: 3-beat packet with tdest=5 is swallowed
    drive(1'b1, 64'hE0, 8'd9, 4'd5, 1'b0);
    #1 chk("inv_b0_tready", 64'(s_tready), 64'h1);
    step();
    chk("inv_b0_tvalid", 64'(m_tvalid), 64'h0);
    drive(1'b1, 64'hE1, 8'd9, 4'd0, 1'b0);
    #1 chk("inv_b1_tready", 64'(s_tready), 64'h1);
    step();
    chk("inv_b1_tvalid", 64'(m_tvalid), 64'h0);
    drive(1'b1, 64'hE2, 8'd9, 4'd2, 1'b1);
    #1 chk("inv_b2_tready", 64'(s_tready), 64'h1);
    step();
    idle();
    chk("inv_b2_tvalid", 64'(m_tvalid), 64'h0);
    chk("inv_drop1", 64'(drop_count), 64'(DROP_INC));

    // invalid dest accepted while a valid beat is held under back-pressure
    m_tready = 4'h0;
    drive(1'b1, 64'h51, 8'd5, 4'd1, 1'b1);
    step();
    drive(1'b1, 64'h52, 8'd5, 4'd9, 1'b1);
    #1 chk("inv_bp_tready", 64'(s_tready), 64'h1);
    step();
    idle();
    chk("inv_bp_tvalid", 64'(m_tvalid), 64'h2);
    chk("inv_bp_tdata", m_tdata, 64'h51);
    chk("inv_drop2", 64'(drop_count), 64'(DROP_INC * 16'd2));
    m_tready = 4'hF;
    drive(1'b1, 64'h61, 8'd6, 4'd3, 1'b1);
    #1 chk("inv_next_tready", 64'(s_tready), 64'h1);
    step();
    idle();
    chk("inv_next_tvalid", 64'(m_tvalid), 64'h8);
    chk("inv_next_tdata", m_tdata, 64'h61);

    // reset mid-packet
    step();
    drive(1'b1, 64'h71, 8'd1, 4'd1, 1'b0);
    step();
    drive(1'b1, 64'h72, 8'd1, 4'd1, 1'b0);
    step();
    chk("rmp_held_tvalid", 64'(m_tvalid), 64'h2);
    idle();
    #2 rst = 1'b1;
    #1 chk("rmp_async_tvalid", 64'(m_tvalid), 64'h0);
    chk("rmp_tready", 64'(s_tready), 64'h0);
    chk("rmp_drop", 64'(drop_count), 64'h0);
    step();
    rst = 1'b0;
    drive(1'b1, 64'h81, 8'd8, 4'd2, 1'b1);
    #1 chk("rmp_next_tready", 64'(s_tready), 64'h1);
    step();
    idle();
    chk("rmp_next_tvalid", 64'(m_tvalid), 64'h4);
    chk("rmp_next_tdata", m_tdata, 64'h81);
    step();
    chk("rmp_end_tvalid", 64'(m_tvalid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
